// File: rtl/lcd_rgb_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_rgb_driver_if
// Purpose  : Bundles the pixel-generator and panel-side signals of the RGB LCD
//            timing driver.
// Ports    : (interface signals)
//   pixel_data  16  RGB565 from pixel generator, one cycle after its coordinate
//   pixel_xpos  11  requested column 1..H_DISP, 0 outside request window
//   pixel_ypos  11  requested row 1..V_DISP, 0 outside request window
//   lcd_hs       1  HSYNC, active-low
//   lcd_vs       1  VSYNC, active-low
//   lcd_de       1  data enable, active-high
//   lcd_rgb     16  panel data, zero outside DE
//   frame_done   1  pulse on the last DE cycle of a frame
// Modports : master = timing driver, slave = generator/panel side
// Revision : 1.0  initial release
// ============================================================================
interface lcd_rgb_driver_if;
  logic [15:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [15:0] lcd_rgb;
  logic        frame_done;

  modport master (
    input  pixel_data,
    output pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_done
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/lcd_rgb_driver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_rgb_driver
// Purpose  : Horizontal/vertical timing generator and panel driver for a
//            parallel RGB LCD. Issues pixel coordinates one cycle ahead of DE
//            so that a generator with one registered cycle of latency lands
//            its data on the pins aligned with lcd_de.
// Ports    :
//   lcd_clk  in   pixel clock
//   sys_rst  in   synchronous active-high reset
//   bus      --   lcd_rgb_driver_if.master (coordinates, syncs, DE, RGB,
//                 frame_done out; pixel_data in)
// Revision : 1.0  initial release
// ============================================================================
module lcd_rgb_driver #(
  parameter int H_SYNC  = 41,
  parameter int H_BACK  = 2,
  parameter int H_DISP  = 480,
  parameter int H_FRONT = 2,
  parameter int V_SYNC  = 10,
  parameter int V_BACK  = 2,
  parameter int V_DISP  = 272,
  parameter int V_FRONT = 2
) (
  input  logic              lcd_clk,
  input  logic              sys_rst,
  lcd_rgb_driver_if.master  bus
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] H_MAX     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] H_LAST    = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] V_LAST    = 11'(V_SYNC + V_BACK + V_DISP - 1);
  // Coordinates are 1-based, so the offset is one less than the window start.
  localparam logic [10:0] H_XOFF    = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_YOFF    = 11'(V_SYNC + V_BACK - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fd_q, fd_d;
  logic        h_act, v_act, req;

  always_comb begin
    h_cnt_d = (h_cnt_q == H_MAX) ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    // The line counter advances on the same edge the pixel counter wraps.
    if (h_cnt_q == H_MAX) begin
      v_cnt_d = (v_cnt_q == V_MAX) ? 11'd0 : v_cnt_q + 11'd1;
    end

    h_act = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    v_act = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    req   = h_act && v_act;

    // Syncs and DE are registered from the same counter state that drives
    // the coordinates, so all three lag the request by exactly one cycle.
    de_d = req;
    hs_d = ~(h_cnt_q < H_SYNC_W);
    vs_d = ~(v_cnt_q < V_SYNC_W);
    fd_d = req && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      h_cnt_q <= 11'd0;
      v_cnt_q <= 11'd0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.pixel_xpos = req ? (h_cnt_q - H_XOFF) : 11'd0;
  assign bus.pixel_ypos = req ? (v_cnt_q - V_YOFF) : 11'd0;
  assign bus.lcd_de     = de_q;
  assign bus.lcd_hs     = hs_q;
  assign bus.lcd_vs     = vs_q;
  assign bus.frame_done = fd_q;
  assign bus.lcd_rgb    = de_q ? bus.pixel_data : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_lcd_rgb_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_rgb_driver
// Purpose  : Self-checking bench for lcd_rgb_driver. A small-parameter build
//            (H 2/1/4/1, V 1/1/3/1) is checked cycle-by-cycle against a
//            reference model plus a hand-derived vector table; a
//            default-parameter build is checked for sync periods, the row-1
//            coordinate sweep and pixel alignment.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_rgb_driver;

  localparam int SH_T = 8;
  localparam int SV_T = 6;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_rgb_driver_if bus_s ();
  lcd_rgb_driver_if bus_b ();

  lcd_rgb_driver #(
    .H_SYNC(2), .H_BACK(1), .H_DISP(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1)
  ) u_small (
    .lcd_clk (clk),
    .sys_rst (rst_s),
    .bus     (bus_s)
  );

  lcd_rgb_driver u_big (
    .lcd_clk (clk),
    .sys_rst (rst_b),
    .bus     (bus_b)
  );

  function automatic logic [15:0] gen(input logic [10:0] x, input logic [10:0] y);
    return {x[4:0], y[5:0], x[4:0]};
  endfunction

  // Model pixel generators: one registered cycle of latency.
  always @(posedge clk) bus_s.pixel_data <= gen(bus_s.pixel_xpos, bus_s.pixel_ypos);
  always @(posedge clk) bus_b.pixel_data <= gen(bus_b.pixel_xpos, bus_b.pixel_ypos);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- small-build reference model and scoreboard -------------
  function automatic bit s_hact(input int h); return (h >= 3) && (h < 7); endfunction
  function automatic bit s_vact(input int v); return (v >= 2) && (v < 5); endfunction

  int m_h = 0, m_v = 0, m_ph = 0, m_pv = 0;
  bit m_rst = 1'b1;
  bit chk_en_s = 1'b0;
  int fd_cnt = 0;
  logic [15:0] sb_s[$];

  always @(posedge clk) begin
    m_rst <= rst_s;
    m_ph  <= m_h;
    m_pv  <= m_v;
    if (rst_s) begin
      m_h <= 0;
      m_v <= 0;
    end else begin
      m_h <= (m_h == SH_T - 1) ? 0 : m_h + 1;
      if (m_h == SH_T - 1) m_v <= (m_v == SV_T - 1) ? 0 : m_v + 1;
      if (s_hact(m_h) && s_vact(m_v))
        sb_s.push_back(gen(11'(m_h - 2), 11'(m_v - 1)));
    end
  end

  always @(negedge clk) begin
    if (chk_en_s) begin
      logic e_de, e_hs, e_vs, e_fd;
      logic [10:0] e_x, e_y;
      e_de = m_rst ? 1'b0 : (s_hact(m_ph) && s_vact(m_pv));
      e_hs = m_rst ? 1'b1 : !(m_ph < 2);
      e_vs = m_rst ? 1'b1 : !(m_pv < 1);
      e_fd = m_rst ? 1'b0 : (m_ph == 6 && m_pv == 4);
      e_x  = (s_hact(m_h) && s_vact(m_v)) ? 11'(m_h - 2) : 11'd0;
      e_y  = (s_hact(m_h) && s_vact(m_v)) ? 11'(m_v - 1) : 11'd0;
      chk("s_de", 32'(bus_s.lcd_de), 32'(e_de));
      chk("s_hs", 32'(bus_s.lcd_hs), 32'(e_hs));
      chk("s_vs", 32'(bus_s.lcd_vs), 32'(e_vs));
      chk("s_fd", 32'(bus_s.frame_done), 32'(e_fd));
      chk("s_xpos", 32'(bus_s.pixel_xpos), 32'(e_x));
      chk("s_ypos", 32'(bus_s.pixel_ypos), 32'(e_y));
      if (bus_s.lcd_de === 1'b1) begin
        if (sb_s.size() == 0) chk("s_de_no_pixel", 32'd1, 32'd0);
        else chk("s_rgb", 32'(bus_s.lcd_rgb), 32'(sb_s.pop_front()));
      end else begin
        chk("s_rgb_idle", 32'(bus_s.lcd_rgb), 32'd0);
      end
      if (bus_s.frame_done === 1'b1) fd_cnt++;
    end
  end

  // ---------------- hand-derived vectors for the small build ---------------
  typedef struct {
    int          cyc;   // edges since reset release
    logic        de, hs, vs, fd;
    logic [10:0] x, y;
  } vec_t;

  vec_t tbl[15];
  logic [15:0] sb_b[$];

  initial begin
    int c;
    tbl[0]  = '{1,  0, 0, 0, 0, 11'd0, 11'd0};
    tbl[1]  = '{3,  0, 1, 0, 0, 11'd0, 11'd0};
    tbl[2]  = '{8,  0, 1, 0, 0, 11'd0, 11'd0};
    tbl[3]  = '{9,  0, 0, 1, 0, 11'd0, 11'd0};
    tbl[4]  = '{19, 0, 1, 1, 0, 11'd1, 11'd1};
    tbl[5]  = '{20, 1, 1, 1, 0, 11'd2, 11'd1};
    tbl[6]  = '{22, 1, 1, 1, 0, 11'd4, 11'd1};
    tbl[7]  = '{23, 1, 1, 1, 0, 11'd0, 11'd0};
    tbl[8]  = '{24, 0, 1, 1, 0, 11'd0, 11'd0};
    tbl[9]  = '{27, 0, 1, 1, 0, 11'd1, 11'd2};
    tbl[10] = '{38, 1, 1, 1, 0, 11'd4, 11'd3};
    tbl[11] = '{39, 1, 1, 1, 1, 11'd0, 11'd0};
    tbl[12] = '{40, 0, 1, 1, 0, 11'd0, 11'd0};
    tbl[13] = '{48, 0, 1, 1, 0, 11'd0, 11'd0};
    tbl[14] = '{49, 0, 0, 0, 0, 11'd0, 11'd0};

    // Reset both builds; small build for 3 edges.
    @(posedge clk);
    chk_en_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_rst_de", 32'(bus_b.lcd_de), 32'd0);
    chk("b_rst_hs", 32'(bus_b.lcd_hs), 32'd1);
    chk("b_rst_vs", 32'(bus_b.lcd_vs), 32'd1);
    chk("b_rst_rgb", 32'(bus_b.lcd_rgb), 32'd0);
    chk("b_rst_xy", {5'd0, bus_b.pixel_xpos, 5'd0, bus_b.pixel_ypos}, 32'd0);
    @(negedge clk) rst_s = 1'b0;

    c = 0;
    for (int i = 0; i < 15; i++) begin
      while (c < tbl[i].cyc) begin
        @(posedge clk);
        c++;
      end
      #1;
      chk($sformatf("t%0d_de", tbl[i].cyc), 32'(bus_s.lcd_de), 32'(tbl[i].de));
      chk($sformatf("t%0d_hs", tbl[i].cyc), 32'(bus_s.lcd_hs), 32'(tbl[i].hs));
      chk($sformatf("t%0d_vs", tbl[i].cyc), 32'(bus_s.lcd_vs), 32'(tbl[i].vs));
      chk($sformatf("t%0d_fd", tbl[i].cyc), 32'(bus_s.frame_done), 32'(tbl[i].fd));
      chk($sformatf("t%0d_x", tbl[i].cyc), 32'(bus_s.pixel_xpos), 32'(tbl[i].x));
      chk($sformatf("t%0d_y", tbl[i].cyc), 32'(bus_s.pixel_ypos), 32'(tbl[i].y));
    end

    // Mid-frame reset while counters sit at (4,3), an active pixel.
    while (c < 124) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk) rst_s = 1'b1;
    @(posedge clk); #1;
    chk("mr_de", 32'(bus_s.lcd_de), 32'd0);
    chk("mr_hs", 32'(bus_s.lcd_hs), 32'd1);
    chk("mr_vs", 32'(bus_s.lcd_vs), 32'd1);
    chk("mr_fd", 32'(bus_s.frame_done), 32'd0);
    chk("mr_rgb", 32'(bus_s.lcd_rgb), 32'd0);
    @(negedge clk) rst_s = 1'b0;
    @(posedge clk); #1;
    chk("mr_vs_fall", 32'(bus_s.lcd_vs), 32'd0);
    chk("mr_hs_fall", 32'(bus_s.lcd_hs), 32'd0);
    repeat (143) @(posedge clk);
    #1;
    // Two full frames before the reset, three after; the interrupted one
    // must not contribute a pulse.
    chk("s_frame_done_count", 32'(fd_cnt), 32'd5);
    @(negedge clk) rst_s = 1'b1;
    @(posedge clk); #1;
    chk("s_sb_empty", 32'(sb_s.size()), 32'd0);

    // ---------------- default build ----------------
    begin
      int fall_last, n_fall, vs_rise, n_sw;
      logic prev_hs, prev_vs;
      logic [10:0] exp_x;
      @(negedge clk) rst_b = 1'b0;
      @(posedge clk); #1;
      chk("b_hs_first", 32'(bus_b.lcd_hs), 32'd0);
      chk("b_vs_first", 32'(bus_b.lcd_vs), 32'd0);
      fall_last = 1; n_fall = 0; vs_rise = -1; n_sw = 0; exp_x = 11'd1;
      prev_hs = bus_b.lcd_hs;
      prev_vs = bus_b.lcd_vs;
      for (int cb = 2; cb <= 6840; cb++) begin
        @(posedge clk); #1;
        if (prev_hs === 1'b1 && bus_b.lcd_hs === 1'b0) begin
          if (n_fall < 3) chk("b_hs_period", 32'(cb - fall_last), 32'd525);
          n_fall++;
          fall_last = cb;
        end
        if (prev_vs === 1'b0 && bus_b.lcd_vs === 1'b1 && vs_rise < 0) vs_rise = cb;
        if (bus_b.lcd_de === 1'b1) begin
          if (sb_b.size() == 0) chk("b_de_no_pixel", 32'd1, 32'd0);
          else chk("b_rgb", 32'(bus_b.lcd_rgb), 32'(sb_b.pop_front()));
        end
        if (bus_b.pixel_xpos != 11'd0 || bus_b.pixel_ypos != 11'd0) begin
          chk("b_sweep_x", 32'(bus_b.pixel_xpos), 32'(exp_x));
          chk("b_sweep_y", 32'(bus_b.pixel_ypos), 32'd1);
          sb_b.push_back(gen(exp_x, 11'd1));
          exp_x++;
          n_sw++;
        end
        prev_hs = bus_b.lcd_hs;
        prev_vs = bus_b.lcd_vs;
      end
      chk("b_sweep_len", 32'(n_sw), 32'd480);
      chk("b_vs_low_len", 32'(vs_rise - 1), 32'd5250);
      chk("b_sb_empty", 32'(sb_b.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
